// File: rtl/step_scheduler.sv
// Step scheduler: advances the downstream FSM state automatically every PERIOD cycles or manually
// on rotary edges, with a post-manual lockout. Define STEP_CNT_EN to add the 8-bit step counter.
module step_scheduler #(
    parameter int PERIOD  = 100000000,
    parameter int LOCKOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rot_event,
    input  logic [1:0] inp,
    input  logic       run,
    input  logic [3:0] next,
    output logic [3:0] curr,
    output logic [1:0] y,
    output logic       step,
    output logic       src,
    output logic       lock
`ifdef STEP_CNT_EN
    ,
    output logic [7:0] step_cnt
`endif
);

    localparam int TW = $clog2(PERIOD);
    localparam int LW = $clog2(LOCKOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] lk_cnt_q, lk_cnt_d;
    logic          prev_rot_q;
    logic [3:0]    curr_q;
    logic [1:0]    y_q;
    logic          src_q;
    logic          step_q;
    logic          rot_edge;
    logic          man_step;
    logic          auto_step;

    assign rot_edge = rot_event & ~prev_rot_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HOLD;
            timer_q  <= '0;
            lk_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, whatever the block order.
            state_q  <= state_d;
            timer_q  <= timer_d;
            lk_cnt_q <= lk_cnt_d;
        end
    end

    // Next-state logic; a manual edge always outranks timer expiry
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        lk_cnt_d  = lk_cnt_q;
        man_step  = 1'b0;
        auto_step = 1'b0;
        case (state_q)
            S_HOLD: begin
                timer_d = '0;
                if (rot_edge) begin
                    man_step = 1'b1;
                    state_d  = S_LOCK;
                end else if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rot_edge) begin
                    man_step = 1'b1;
                    timer_d  = '0;
                    state_d  = S_LOCK;
                end else if (timer_q == TIMER_LAST) begin
                    auto_step = 1'b1;
                    timer_d   = '0;
                end else if (!run) begin
                    timer_d = '0;
                    state_d = S_HOLD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_LOCK: begin
                timer_d = '0;
                if (lk_cnt_q == LOCK_LAST) begin
                    lk_cnt_d = '0;
                    state_d  = run ? S_RUN : S_HOLD;
                end else begin
                    lk_cnt_d = lk_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d  = S_HOLD;
                timer_d  = '0;
                lk_cnt_d = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        lock = (state_q == S_LOCK);
        curr = curr_q;
        y    = y_q;
        src  = src_q;
        step = step_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: prev_rot resets high so a level already high at release is not seen as an edge.
            prev_rot_q <= 1'b1;
            curr_q     <= '0;
            y_q        <= '0;
            src_q      <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            prev_rot_q <= rot_event;
            step_q     <= man_step | auto_step;
            if (man_step) begin
                curr_q <= next;
                y_q    <= inp;
                src_q  <= 1'b1;
            end else if (auto_step) begin
                curr_q <= next;
                src_q  <= 1'b0;
            end
        end
    end

`ifdef STEP_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (man_step | auto_step) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign step_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler (PERIOD=8, LOCKOUT=4): a cycle model built from the
// scheduling rules is compared every cycle, plus hand-computed checkpoints per scenario.
module tb_step_scheduler;

    localparam int PERIOD  = 8;
    localparam int LOCKOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rot_event;
    logic [1:0] inp;
    logic       run;
    logic [3:0] next;
    logic [3:0] curr;
    logic [1:0] y;
    logic       step;
    logic       src;
    logic       lock;
`ifdef STEP_CNT_EN
    logic [7:0] step_cnt;
`endif

    step_scheduler #(.PERIOD(PERIOD), .LOCKOUT(LOCKOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rot_event (rot_event),
        .inp       (inp),
        .run       (run),
        .next      (next),
        .curr      (curr),
        .y         (y),
        .step      (step),
        .src       (src),
        .lock      (lock)
`ifdef STEP_CNT_EN
        ,
        .step_cnt  (step_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining lockout cycles, whether auto stepping is active, and
    // cycles elapsed in the current auto period.
    logic [3:0] m_curr = '0;
    logic [1:0] m_y    = '0;
    logic       m_src  = 1'b0;
    logic       m_step = 1'b0;
    int         m_cnt  = 0;
    logic       m_prev = 1'b1;
    int         lock_left = 0;
    bit         running   = 1'b0;
    int         elapsed   = 0;
    bit         rise;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_curr = '0; m_y = '0; m_src = 1'b0; m_step = 1'b0; m_cnt = 0;
                m_prev = 1'b1; lock_left = 0; running = 1'b0; elapsed = 0;
            end else begin
                rise   = rot_event && !m_prev;
                m_prev = rot_event;
                m_step = 1'b0;
                if (lock_left > 0) begin
                    lock_left--;
                    if (lock_left == 0) running = run;
                end else if (rise) begin
                    m_curr = next; m_y = inp; m_src = 1'b1; m_step = 1'b1;
                    m_cnt = (m_cnt + 1) % 256;
                    lock_left = LOCKOUT;
                    elapsed = 0;
                end else if (running) begin
                    if (elapsed == PERIOD - 1) begin
                        m_curr = next; m_src = 1'b0; m_step = 1'b1;
                        m_cnt = (m_cnt + 1) % 256;
                        elapsed = 0;
                    end else if (!run) begin
                        running = 1'b0;
                        elapsed = 0;
                    end else begin
                        elapsed++;
                    end
                end else if (run) begin
                    running = 1'b1;
                    elapsed = 0;
                end
            end
        end
    end

    // Per-cycle compare and DUT event tallies
    int dut_steps   = 0;
    int lock_cycles = 0;

    always @(negedge clk) begin
        check("curr", curr, m_curr);
        check("y", y, m_y);
        check("src", src, m_src);
        check("step", step, m_step);
        check("lock", lock, lock_left > 0);
`ifdef STEP_CNT_EN
        check("step_cnt", step_cnt, m_cnt);
`endif
        if (step === 1'b1) dut_steps++;
        if (lock === 1'b1) lock_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int base;

    initial begin
        rst_n = 1'b0; rot_event = 1'b1; run = 1'b0; inp = 2'd0; next = 4'd0;

        // Release with rot_event held high: no step
        tick(3);
        rst_n = 1'b1;
        tick(20); settle();
        check("rel_curr", curr, 4'd0);
        check("rel_steps", dut_steps, 0);
        check("rel_lock", lock, 1'b0);

        // Auto stepping: steps 9, 17, 25 edges after run rises
        tick(1);
        rot_event = 1'b0; next = 4'd5; run = 1'b1; base = dut_steps;
        tick(26); settle();
        check("auto_steps", dut_steps - base, 3);
        check("auto_curr", curr, 4'd5);
        check("auto_src", src, 1'b0);
        check("auto_y", y, 2'd0);
        tick(1);
        run = 1'b0;
        tick(4); settle();
        check("hold_steps", dut_steps - base, 3);
        check("hold_curr", curr, 4'd5);

        // Manual step from HOLD
        tick(1);
        inp = 2'b10; next = 4'd9; rot_event = 1'b1; base = dut_steps; lock_cycles = 0;
        tick(1); settle();
        check("man_curr", curr, 4'd9);
        check("man_y", y, 2'd2);
        check("man_src", src, 1'b1);
        check("man_lock", lock, 1'b1);
        tick(8); settle();
        check("man_lock_cycles", lock_cycles, 4);
        check("man_steps", dut_steps - base, 1);

        // Second edge inside lockout is dropped
        tick(1);
        rot_event = 1'b0;
        tick(2);
        rot_event = 1'b1; next = 4'd3; inp = 2'd1; base = dut_steps;
        tick(1);
        rot_event = 1'b0; next = 4'd12; inp = 2'd0;
        tick(1);
        rot_event = 1'b1;
        tick(10); settle();
        check("lockout_steps", dut_steps - base, 1);
        check("lockout_curr", curr, 4'd3);
        check("lockout_y", y, 2'd1);

        // Edge coinciding with timer expiry: one manual step, timer restarts after lockout
        tick(1);
        rot_event = 1'b0; run = 1'b1; next = 4'd7; inp = 2'd3; base = dut_steps;
        tick(8);
        rot_event = 1'b1;
        tick(1); settle();
        check("tie_steps", dut_steps - base, 1);
        check("tie_src", src, 1'b1);
        check("tie_y", y, 2'd3);
        next = 4'd8;
        tick(11); settle();
        check("tie_gap_steps", dut_steps - base, 1);
        tick(1); settle();
        check("tie_next_steps", dut_steps - base, 2);
        check("tie_next_src", src, 1'b0);
        check("tie_next_curr", curr, 4'd8);
        check("tie_next_y", y, 2'd3);

        // run dropped mid-count returns to HOLD without stepping
        tick(3);
        run = 1'b0;
        tick(12); settle();
        check("drop_steps", dut_steps - base, 2);
        check("drop_curr", curr, 4'd8);
        check("drop_lock", lock, 1'b0);

        // Reset during lockout abandons it; rot_event held high through release
        tick(1);
        rot_event = 1'b0;
        tick(2);
        rot_event = 1'b1; next = 4'd4; inp = 2'd1; base = dut_steps;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10); settle();
        check("rst_steps", dut_steps - base, 1);
        check("rst_curr", curr, 4'd0);
        check("rst_y", y, 2'd0);
        check("rst_src", src, 1'b0);
        check("rst_lock", lock, 1'b0);

        // 256 auto steps: counter wraps
        tick(1);
        rot_event = 1'b0; run = 1'b1; next = 4'd6; base = dut_steps;
        tick(2041); settle();
        check("wrap_steps_255", dut_steps - base, 255);
`ifdef STEP_CNT_EN
        check("wrap_cnt_255", step_cnt, 8'd255);
`endif
        tick(8); settle();
        check("wrap_steps_256", dut_steps - base, 256);
        check("wrap_curr", curr, 4'd6);
`ifdef STEP_CNT_EN
        check("wrap_cnt_0", step_cnt, 8'd0);
`endif
        run = 1'b0;
        tick(5); settle();
        check("end_lock", lock, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
